// File: rtl/sr_seq_pkg.sv
// rtl/sr_seq_pkg.sv - shared encodings and bit positions for the SR latch sequencer
package sr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_SET  = 2'd1,
        CMD_RST  = 2'd2,
        CMD_TOG  = 2'd3
    } cmd_e;

    localparam int UO_Q       = 0;
    localparam int UO_BUSY    = 1;
    localparam int UO_ERR     = 2;
    localparam int UO_CONF    = 3;
    localparam int UO_CNT_LSB = 4;

    localparam int UIO_Q  = 0;
    localparam int UIO_QN = 1;
    localparam int UIO_S  = 2;
    localparam int UIO_R  = 3;

    localparam logic [7:0] UIO_OE_VAL = 8'h0C;

    // Toggle becomes a concrete set/reset based on the latch state we believe in.
    function automatic cmd_e resolve_cmd(input cmd_e cmd, input logic q_shadow);
        if (cmd == CMD_TOG) begin
            return q_shadow ? CMD_RST : CMD_SET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/sr_seq_sync.sv
// rtl/sr_seq_sync.sv - multi-flop input synchronizer with registered rising-edge output
module sr_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
        end
    end

    assign level = chain[STAGES-1];

endmodule

// File: rtl/tt_um_sr_latch_seq.sv
// rtl/tt_um_sr_latch_seq.sv - non-overlapping S/R pulse sequencer for an external NOR latch
// Optional readback/check path enabled by SR_SEQ_READBACK_EN.
import sr_seq_pkg::*;

module tt_um_sr_latch_seq #(
    parameter int PULSE_W     = 4,
    parameter int SETTLE_W    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] PULSE_M1  = 4'(PULSE_W - 1);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_W - 1);

    // Index 0..2: set/rst/tog requests, 3: clr_flags.
    logic [3:0] req_raw, req_lvl, req_rise;
    assign req_raw = {ui_in[7], ui_in[2:0]};

    for (genvar i = 0; i < 4; i++) begin : g_req_sync
        sr_seq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_raw[i]),
            .level (req_lvl[i]),
            .rise  (req_rise[i])
        );
    end

`ifdef SR_SEQ_READBACK_EN
    logic [1:0] rb_lvl, rb_rise;
    for (genvar i = 0; i < 2; i++) begin : g_rb_sync
        sr_seq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (uio_in[i]),
            .level (rb_lvl[i]),
            .rise  (rb_rise[i])
        );
    end
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[6:3], req_lvl[2:0], req_rise[3], uio_in[7:2], rb_rise};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[6:3], req_lvl[2:0], req_rise[3], uio_in};
`endif

    logic set_e, rst_e, tog_e, clr_lvl, conflict_evt;
    cmd_e req;
    assign set_e        = req_rise[0];
    assign rst_e        = req_rise[1];
    assign tog_e        = req_rise[2];
    assign clr_lvl      = req_lvl[3];
    assign conflict_evt = (set_e & rst_e) | (set_e & tog_e) | (rst_e & tog_e);

    always_comb begin
        req = CMD_NONE;
        if (!conflict_evt) begin
            if (set_e)      req = CMD_SET;
            else if (rst_e) req = CMD_RST;
            else if (tog_e) req = CMD_TOG;
        end
    end

    state_e     state, state_n;
    cmd_e       pend, pend_n, nxt, rc;
    logic [3:0] cnt, cnt_n, cmd_cnt, cmd_cnt_n;
    logic       q_shadow, q_n, drive_s, ds_n, drive_r, dr_n;
    logic       err, err_n, conflict, conf_n;
    logic       start, finish, err_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pend     <= CMD_NONE;
            cnt      <= '0;
            cmd_cnt  <= '0;
            q_shadow <= 1'b0;
            drive_s  <= 1'b0;
            drive_r  <= 1'b0;
            err      <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_n;
            pend     <= pend_n;
            cnt      <= cnt_n;
            cmd_cnt  <= cmd_cnt_n;
            q_shadow <= q_n;
            drive_s  <= ds_n;
            drive_r  <= dr_n;
            err      <= err_n;
            conflict <= conf_n;
        end
    end

    always_comb begin
        state_n   = state;
        pend_n    = pend;
        cnt_n     = cnt;
        cmd_cnt_n = cmd_cnt;
        q_n       = q_shadow;
        ds_n      = drive_s;
        dr_n      = drive_r;
        err_n     = err;
        conf_n    = conflict;
        start     = 1'b0;
        finish    = 1'b0;
        err_evt   = 1'b0;
        nxt       = req;
        rc        = CMD_NONE;

        // While busy the newest request replaces whatever was pending.
        if (state != ST_IDLE && req != CMD_NONE) pend_n = req;

        case (state)
            ST_IDLE: start = (req != CMD_NONE);
            ST_DRIVE: begin
                if (cnt == 4'd0) begin
                    state_n = ST_SETTLE;
                    cnt_n   = SETTLE_M1;
                    ds_n    = 1'b0;
                    dr_n    = 1'b0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
`ifdef SR_SEQ_READBACK_EN
                    state_n = ST_CHECK;
`else
                    finish  = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_CHECK: begin
`ifdef SR_SEQ_READBACK_EN
                err_evt = (rb_lvl[UIO_Q] == rb_lvl[UIO_QN]) || (rb_lvl[UIO_Q] != q_shadow);
                finish  = 1'b1;
`else
                state_n = ST_IDLE;
`endif
            end
            default: state_n = ST_IDLE;
        endcase

        if (finish) begin
            nxt     = (req != CMD_NONE) ? req : pend;
            state_n = ST_IDLE;
            pend_n  = CMD_NONE;
            start   = (nxt != CMD_NONE);
        end

        if (start) begin
            rc        = resolve_cmd(nxt, q_shadow);
            state_n   = ST_DRIVE;
            cnt_n     = PULSE_M1;
            ds_n      = (rc == CMD_SET);
            dr_n      = (rc == CMD_RST);
            q_n       = (rc == CMD_SET);
            cmd_cnt_n = cmd_cnt + 4'd1;
            pend_n    = CMD_NONE;
        end

        // Set events beat a simultaneous clear.
        if (clr_lvl) begin
            err_n  = 1'b0;
            conf_n = 1'b0;
        end
        if (err_evt)      err_n  = 1'b1;
        if (conflict_evt) conf_n = 1'b1;
    end

    always_comb begin
        uo_out                         = '0;
        uo_out[UO_Q]                   = q_shadow;
        uo_out[UO_BUSY]                = (state != ST_IDLE);
`ifdef SR_SEQ_READBACK_EN
        uo_out[UO_ERR]                 = err;
`else
        uo_out[UO_ERR]                 = 1'b0;
`endif
        uo_out[UO_CONF]                = conflict;
        uo_out[UO_CNT_LSB +: 4]        = cmd_cnt;
        uio_out                        = '0;
        uio_out[UIO_S]                 = drive_s;
        uio_out[UIO_R]                 = drive_r;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_sr_latch_seq.sv
// tb/tb_tt_um_sr_latch_seq.sv - scoreboard bench for the SR latch sequencer
module tb_tt_um_sr_latch_seq;

    localparam int P = 4;
    localparam int S = 3;
`ifdef SR_SEQ_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in, uo_out, uio_out, uio_oe;
    logic       lq = 1'b0;
    logic       stuck_q0 = 1'b0;

    always #5 clk = ~clk;

    // External NOR latch model; stuck_q0 forces the Q readback low.
    always @(posedge uio_out[2] or posedge uio_out[3]) lq <= uio_out[2];
    assign uio_in = {6'b0, ~lq, lq & ~stuck_q0};

    tt_um_sr_latch_seq #(.PULSE_W(P), .SETTLE_W(S), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic       is_set;
        logic       q;
        logic [3:0] cnt;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic push_exp(input logic is_set, input logic q, input logic [3:0] cnt, input int gap);
        exp_t e;
        e.is_set = is_set;
        e.q      = q;
        e.cnt    = cnt;
        e.gap    = gap;
        sb.push_back(e);
    endtask

    task automatic monitor();
        logic in_pulse = 1'b0;
        logic cur_set = 1'b0;
        int   width = 0;
        int   gap = -1;
        int   start_gap = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pulse = 1'b0;
                gap      = -1;
            end else begin
                checks++;
                if (uio_out[2] && uio_out[3]) begin
                    failures++;
                    $display("FAIL sr_overlap got=%b required=not_both", uio_out[3:2]);
                end
                if (uio_out[2] || uio_out[3]) begin
                    if (!in_pulse) begin
                        in_pulse  = 1'b1;
                        width     = 0;
                        cur_set   = uio_out[2];
                        start_gap = gap;
                    end
                    width++;
                end else if (in_pulse) begin
                    in_pulse = 1'b0;
                    gap      = 1;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse got set=%0b required=none", cur_set);
                    end else begin
                        e = sb.pop_front();
                        checks += 4;
                        if (cur_set !== e.is_set) begin
                            failures++;
                            $display("FAIL pulse_kind got set=%0b required=%0b", cur_set, e.is_set);
                        end
                        if (width != P) begin
                            failures++;
                            $display("FAIL pulse_width got=%0d required=%0d", width, P);
                        end
                        if (uo_out[0] !== e.q) begin
                            failures++;
                            $display("FAIL q_shadow got=%0b required=%0b", uo_out[0], e.q);
                        end
                        if (uo_out[7:4] !== e.cnt) begin
                            failures++;
                            $display("FAIL cmd_cnt got=%0d required=%0d", uo_out[7:4], e.cnt);
                        end
                        if (e.gap >= 0) begin
                            checks++;
                            if (start_gap != e.gap) begin
                                failures++;
                                $display("FAIL idle_gap got=%0d required=%0d", start_gap, e.gap);
                            end
                        end
                    end
                end else if (gap >= 0) begin
                    gap++;
                end
            end
        end
    endtask

    task automatic pulse_in(input logic [7:0] mask);
        @(negedge clk);
        ui_in = ui_in | mask;
        @(negedge clk);
        ui_in = ui_in & ~mask;
    endtask

    task automatic run_wait(output int busy_cycles);
        int t;
        busy_cycles = 0;
        t = 0;
        while (!uo_out[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (uo_out[1] && t < 80) begin
            busy_cycles++;
            @(negedge clk);
            t++;
        end
        checks++;
        if (uo_out[1] !== 1'b0 || busy_cycles == 0) begin
            failures++;
            $display("FAIL busy_window got busy=%0b cycles=%0d required=idle_after_busy", uo_out[1], busy_cycles);
        end
    endtask

    task automatic wait_drive_s();
        int t = 0;
        while (!uio_out[2] && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (uio_out[2] !== 1'b1) begin
            failures++;
            $display("FAIL drive_s_start got=%0b required=1", uio_out[2]);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo got=%h required=00", uo_out); end
        if (uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio got=%h required=00", uio_out); end
        if (uio_oe !== 8'h0C) begin failures++; $display("FAIL reset_oe got=%h required=0c", uio_oe); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_set();
        int bc;
        push_exp(1'b1, 1'b1, 4'd1, -1);
        pulse_in(8'h01);
        run_wait(bc);
        checks += 4;
        if (bc != P + S + RB) begin failures++; $display("FAIL busy_len got=%0d required=%0d", bc, P + S + RB); end
        if (uo_out[0] !== 1'b1) begin failures++; $display("FAIL set_q got=%0b required=1", uo_out[0]); end
        if (uo_out[7:4] !== 4'd1) begin failures++; $display("FAIL set_cnt got=%0d required=1", uo_out[7:4]); end
        if (uo_out[2] !== 1'b0) begin failures++; $display("FAIL set_err got=%0b required=0", uo_out[2]); end
    endtask

    task automatic test_conflict();
        logic [3:0] c0;
        c0 = uo_out[7:4];
        pulse_in(8'h03);
        repeat (8) @(negedge clk);
        checks += 3;
        if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL conflict_set got=%0b required=1", uo_out[3]); end
        if (uo_out[1] !== 1'b0) begin failures++; $display("FAIL conflict_busy got=%0b required=0", uo_out[1]); end
        if (uo_out[7:4] !== c0) begin failures++; $display("FAIL conflict_cnt got=%0d required=%0d", uo_out[7:4], c0); end
        pulse_in(8'h80);
        repeat (4) @(negedge clk);
        checks++;
        if (uo_out[3] !== 1'b0) begin failures++; $display("FAIL conflict_clr got=%0b required=0", uo_out[3]); end
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [3:0] c0;
        c0 = uo_out[7:4];
        push_exp(1'b1, 1'b1, c0 + 4'd1, -1);
        push_exp(1'b0, 1'b0, c0 + 4'd2, S + RB);
        pulse_in(8'h01);
        wait_drive_s();
        pulse_in(8'h02);
        pulse_in(8'h04);
        run_wait(bc);
        checks += 2;
        if (uo_out[7:4] !== c0 + 4'd2) begin failures++; $display("FAIL b2b_cnt got=%0d required=%0d", uo_out[7:4], c0 + 4'd2); end
        if (uo_out[0] !== 1'b0) begin failures++; $display("FAIL b2b_q got=%0b required=0", uo_out[0]); end
    endtask

`ifdef SR_SEQ_READBACK_EN
    task automatic test_readback();
        int bc;
        logic [3:0] c0;
        c0 = uo_out[7:4];
        stuck_q0 = 1'b1;
        push_exp(1'b1, 1'b1, c0 + 4'd1, -1);
        pulse_in(8'h01);
        run_wait(bc);
        checks++;
        if (uo_out[2] !== 1'b1) begin failures++; $display("FAIL err_stuck got=%0b required=1", uo_out[2]); end
        stuck_q0 = 1'b0;
        push_exp(1'b0, 1'b0, c0 + 4'd2, -1);
        pulse_in(8'h02);
        run_wait(bc);
        checks++;
        if (uo_out[2] !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b required=1", uo_out[2]); end
        pulse_in(8'h80);
        repeat (4) @(negedge clk);
        checks++;
        if (uo_out[2] !== 1'b0) begin failures++; $display("FAIL err_clr got=%0b required=0", uo_out[2]); end
    endtask
`endif

    task automatic test_wrap();
        int bc;
        logic q;
        apply_reset();
        q = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            q = ~q;
            push_exp(q, q, 4'(i), -1);
            pulse_in(8'h04);
            run_wait(bc);
        end
        checks += 2;
        if (uo_out[7:4] !== 4'd0) begin failures++; $display("FAIL wrap_cnt got=%0d required=0", uo_out[7:4]); end
        if (uo_out[0] !== 1'b0) begin failures++; $display("FAIL wrap_q got=%0b required=0", uo_out[0]); end
    endtask

    task automatic test_reset_mid_pulse();
        pulse_in(8'h01);
        wait_drive_s();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (uio_out !== 8'h00) begin failures++; $display("FAIL async_drive got=%h required=00", uio_out); end
        if (uo_out !== 8'h00) begin failures++; $display("FAIL async_uo got=%h required=00", uo_out); end
        if (uio_oe !== 8'h0C) begin failures++; $display("FAIL async_oe got=%h required=0c", uio_oe); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks += 2;
        if (uo_out !== 8'h00) begin failures++; $display("FAIL post_reset_uo got=%h required=00", uo_out); end
        if (uio_out !== 8'h00) begin failures++; $display("FAIL post_reset_uio got=%h required=00", uio_out); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_set();
        test_conflict();
        test_back_to_back();
`ifdef SR_SEQ_READBACK_EN
        test_readback();
`endif
        test_wrap();
        test_reset_mid_pulse();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pulses_missing got=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
